// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier (RV64M MUL/MULH/MULHSU/MULHU), one partial product per cycle.
// Optional 32-bit word ops (mulw port, 17 digits) are enabled by defining MUL_WORD_EN.
module mul_booth_iter #(
  parameter int XLEN   = 64,
  parameter int NDIGIT = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
`ifdef MUL_WORD_EN
  input  logic            mulw,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int EW    = XLEN + 2;
  localparam int PW    = 2 * EW;
  localparam int CW    = $clog2(NDIGIT + 1);
  localparam int WDIG  = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [EW-1:0]   r_x;
  logic [EW:0]     r_y;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_ndig;
  logic            r_mul_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
`ifdef MUL_WORD_EN
  logic            r_word;
`endif

  logic [EW-1:0]   w_x_ext;
  logic [EW-1:0]   w_y_ext;
  logic [CW-1:0]   w_ndig;
  logic [PW-1:0]   w_x_sx;
  logic [PW-1:0]   w_sel;
  logic            w_neg;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_pp_sh;
  logic [CW:0]     w_shamt;
  logic            w_unused;

  // Operand extension at accept; word ops extend bit 31 up to the full 66-bit width.
  always_comb begin
    w_x_ext = {{(EW-XLEN){mul_signed[1] & multiplicand[XLEN-1]}}, multiplicand};
    w_y_ext = {{(EW-XLEN){mul_signed[0] & multiplier[XLEN-1]}}, multiplier};
    w_ndig  = CW'(NDIGIT);
`ifdef MUL_WORD_EN
    if (mulw) begin
      w_x_ext = {{(EW-32){mul_signed[1] & multiplicand[31]}}, multiplicand[31:0]};
      w_y_ext = {{(EW-32){mul_signed[0] & multiplier[31]}}, multiplier[31:0]};
      w_ndig  = CW'(WDIG);
    end
`endif
  end

  always_comb begin
    w_x_sx = {{(PW-EW){r_x[EW-1]}}, r_x};
    w_sel  = '0;
    w_neg  = 1'b0;
    case (r_y[2:0])
      3'b001, 3'b010: w_sel = w_x_sx;
      3'b011:         w_sel = w_x_sx << 1;
      3'b100: begin
        w_sel = w_x_sx << 1;
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_sel = w_x_sx;
        w_neg = 1'b1;
      end
      default:        w_sel = '0;
    endcase
    w_pp    = w_neg ? (~w_sel + PW'(1)) : w_sel;
    w_shamt = {r_cnt, 1'b0};
    w_pp_sh = w_pp << w_shamt;
  end

  // Bits above the 128-bit product only carry the modular wrap of the accumulator.
  assign w_unused = ^r_acc[PW-1:2*XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ndig      <= '0;
      r_mul_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
`ifdef MUL_WORD_EN
      r_word      <= 1'b0;
`endif
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_ready <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mul_valid) begin
            r_x         <= w_x_ext;
            r_y         <= {w_y_ext, 1'b0};
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ndig      <= w_ndig;
            r_mul_ready <= 1'b0;
            r_state     <= S_BUSY;
`ifdef MUL_WORD_EN
            r_word      <= mulw;
`endif
          end
        end
        S_BUSY: begin
          if (r_cnt < r_ndig) begin
            r_acc <= r_acc + w_pp_sh;
            r_y   <= $signed(r_y) >>> 2;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            // Extra cycle after the last accumulate publishes the product.
            r_hi        <= r_acc[2*XLEN-1:XLEN];
            r_lo        <= r_acc[XLEN-1:0];
`ifdef MUL_WORD_EN
            if (r_word) begin
              r_hi <= '0;
              r_lo <= {{(XLEN-32){r_acc[31]}}, r_acc[31:0]};
            end
`endif
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_mul_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mul_ready <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mul_ready = r_mul_ready;
  assign out_valid = r_out_valid;
  assign result_hi = r_hi;
  assign result_lo = r_lo;

endmodule
